spi_wr_arbiter: RTL and testbench

//  Shares one SPI_MASTER write channel (WR/DATA/BUSY) between N_REQ requesters of 64-bit words.

---
 rtl/spi_wr_arbiter_pkg.sv | 20 ++
 rtl/spi_wr_arbiter_if.sv | 28 ++
 rtl/spi_wr_arbiter_rr_arbiter.sv | 31 +++
 rtl/spi_wr_arbiter.sv | 95 +++++++++
 tb/tb_spi_wr_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_wr_arbiter_pkg.sv
// Shared SPI link definitions: word width, arbiter FSM encoding and the
// 64-bit SPI word field layout used by the SPI_MASTER/SPI_SLAVE users.
package spi_wr_arbiter_pkg;

  localparam int SPI_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [47:0] payload;
  } spi_word_t;

endpackage

// File: rtl/spi_wr_arbiter_if.sv
// Requester-side and SPI_MASTER-side signals of the write arbiter.
// The arbiter takes the slave view; the sources/master model take the master view.
interface spi_wr_arbiter_if
  import spi_wr_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = SPI_DATA_W
);
  logic [N_REQ-1:0]        REQ_VALID;
  logic [N_REQ*DATA_W-1:0] REQ_DATA;
  logic [N_REQ-1:0]        REQ_ACK;
  logic                    WR;
  logic [DATA_W-1:0]       DATA;
  logic                    BUSY;
  logic [2:0]              GRANT_ID;
  logic                    ERR_TMO;
  logic [15:0]             XFER_CNT;

  modport slave (
    input  REQ_VALID, REQ_DATA, BUSY,
    output REQ_ACK, WR, DATA, GRANT_ID, ERR_TMO, XFER_CNT
  );

  modport master (
    output REQ_VALID, REQ_DATA, BUSY,
    input  REQ_ACK, WR, DATA, GRANT_ID, ERR_TMO, XFER_CNT
  );
endinterface

// File: rtl/spi_wr_arbiter_rr_arbiter.sv
// Combinational round-robin search: first valid requester at or after the
// pointer, ascending with wrap-around.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [2:0]       i_ptr,
  output logic             o_any,
  output logic [2:0]       o_idx
);
  localparam int IW = $clog2(2 * N_REQ);

  logic [2*N_REQ-1:0] w_req2;
  logic [IW-1:0]      w_pos;

  // Doubling the request vector turns the wrapped search into a linear one.
  assign w_req2 = {i_req, i_req};

  always_comb begin
    o_any = 1'b0;
    o_idx = 3'd0;
    w_pos = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = IW'(i_ptr) + IW'(k);
      if (w_req2[w_pos]) begin
        o_any = 1'b1;
        o_idx = (w_pos >= IW'(N_REQ)) ? 3'(w_pos - IW'(N_REQ)) : 3'(w_pos);
      end
    end
  end
endmodule

// File: rtl/spi_wr_arbiter.sv
// Round-robin sharing of one SPI_MASTER write channel between N_REQ sources,
// with BUSY-rise timeout detection and a completed-transfer counter.
module spi_wr_arbiter
  import spi_wr_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = SPI_DATA_W,
  parameter int BUSY_TMO = 255
) (
  input  logic            CLK,
  input  logic            RESET_N,
  spi_wr_arbiter_if.slave bus
);
  arb_state_t        r_state, w_next;
  logic [2:0]        r_ptr, r_grant, w_win, w_ptr_nxt;
  logic              w_any, w_grant, w_tmo, w_done;
  logic [DATA_W-1:0] r_data, w_sel;
  logic              r_wr, r_err;
  logic [15:0]       r_xfer;
  logic [7:0]        r_cnt;
  logic [N_REQ-1:0]  w_ack;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req (bus.REQ_VALID),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_win)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_grant) w_next = ST_LAUNCH;
      ST_LAUNCH:  w_next = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (bus.BUSY)  w_next = ST_WAIT_LO;
        else if (w_tmo) w_next = ST_IDLE;
      end
      ST_WAIT_LO: if (w_done) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Arbitration only happens in IDLE with the link quiet.
  always_comb begin
    w_grant   = (r_state == ST_IDLE) && !bus.BUSY && w_any;
    w_tmo     = (r_state == ST_WAIT_HI) && !bus.BUSY && (r_cnt == 8'(BUSY_TMO));
    w_done    = (r_state == ST_WAIT_LO) && !bus.BUSY;
    w_ack     = (r_state == ST_LAUNCH) ? (N_REQ'(1) << r_grant) : '0;
    w_ptr_nxt = (r_grant == 3'(N_REQ - 1)) ? 3'd0 : r_grant + 3'd1;
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == 3'(i)) w_sel = bus.REQ_DATA[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_data  <= '0;
      r_grant <= 3'd0;
      r_ptr   <= 3'd0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_xfer  <= 16'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_wr  <= (r_state == ST_LAUNCH);
      r_err <= w_tmo;
      if (w_grant) begin
        r_data  <= w_sel;
        r_grant <= w_win;
      end
      // Counts cycles spent in WAIT_HI; zero on entry from LAUNCH.
      if (r_state == ST_WAIT_HI) r_cnt <= r_cnt + 8'd1;
      else                       r_cnt <= 8'd0;
      if (w_tmo || w_done) r_ptr <= w_ptr_nxt;
      if (w_done)          r_xfer <= r_xfer + 16'd1;
    end
  end

  assign bus.REQ_ACK  = w_ack;
  assign bus.WR       = r_wr;
  assign bus.DATA     = r_data;
  assign bus.GRANT_ID = r_grant;
  assign bus.ERR_TMO  = r_err;
  assign bus.XFER_CNT = r_xfer;
endmodule

// File: tb/tb_spi_wr_arbiter.sv
// Directed/randomized bench for spi_wr_arbiter: requesters and the SPI_MASTER
// BUSY line are modelled here, grants/counts predicted by a round-robin model.
module tb_spi_wr_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 64;
  localparam int TMO = 12;

  logic clk;
  logic rst_n;

  spi_wr_arbiter_if #(.N_REQ(NR), .DATA_W(DW)) bus ();

  spi_wr_arbiter #(.N_REQ(NR), .DATA_W(DW), .BUSY_TMO(TMO)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          rem [NR];
  logic [63:0] word [NR];
  int          ptr_m;
  logic [15:0] xfer_m;
  int          cur_id;
  logic [63:0] cur_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First valid requester at or after p, wrapping.
  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.REQ_VALID[i]          = (rem[i] != 0);
      bus.REQ_DATA[i*DW +: DW]  = word[i];
    end
  endtask

  task automatic launch(output int lat);
    logic [NR-1:0] v;
    bit found;
    for (int i = 0; i < NR; i++) v[i] = (rem[i] != 0);
    cur_id = pick(v, ptr_m);
    found = 0;
    lat = 0;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) @(negedge clk);
      if (|bus.REQ_ACK) begin
        found = 1;
        lat = i;
        break;
      end
    end
    chk("ack_seen", 64'(found), 64'd1);
    chk("ack_vec", 64'(bus.REQ_ACK), 64'(1) << cur_id);
    chk("grant_id", 64'(bus.GRANT_ID), 64'(cur_id));
    cur_data = word[cur_id];
    rem[cur_id]--;
    if (rem[cur_id] != 0) word[cur_id] = {$urandom, $urandom};
    drive();
    @(negedge clk);
    chk("wr_pulse", 64'(bus.WR), 64'd1);
    chk("data_at_wr", bus.DATA, cur_data);
    chk("ack_single", 64'(bus.REQ_ACK), 64'd0);
  endtask

  task automatic finish_ok(input int blen, input bit pulse2);
    int d;
    bit stable;
    d = $urandom_range(0, 2);
    stable = 1;
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      if (bus.WR !== 1'b0) stable = 0;
    end
    bus.BUSY = 1'b1;
    for (int i = 0; i < blen; i++) begin
      @(negedge clk);
      if (bus.DATA !== cur_data || bus.WR !== 1'b0 || bus.REQ_ACK !== '0) stable = 0;
      if (pulse2) bus.REQ_VALID[2] = (i == 1);
    end
    bus.BUSY = 1'b0;
    @(negedge clk);
    xfer_m = xfer_m + 16'd1;
    ptr_m  = (cur_id + 1) % NR;
    chk("data_stable", 64'(stable), 64'd1);
    chk("xfer_cnt", 64'(bus.XFER_CNT), 64'(xfer_m));
  endtask

  task automatic finish_tmo();
    int n;
    bit wr_low;
    n = 0;
    wr_low = 0;
    for (int i = 1; i <= TMO + 10; i++) begin
      @(negedge clk);
      if (i == 1) wr_low = (bus.WR === 1'b0);
      if (bus.ERR_TMO === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("wr_one_cycle", 64'(wr_low), 64'd1);
    chk("tmo_delay", 64'(n), 64'(TMO + 1));
    chk("xfer_after_tmo", 64'(bus.XFER_CNT), 64'(xfer_m));
    ptr_m = (cur_id + 1) % NR;
    @(negedge clk);
    chk("err_one_cycle", 64'(bus.ERR_TMO), 64'd0);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    bit quiet;
    quiet = 1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.REQ_ACK !== '0 || bus.WR !== 1'b0) quiet = 0;
    end
    chk(tag, 64'(quiet), 64'd1);
  endtask

  task automatic check_reset_state();
    chk("rst_wr", 64'(bus.WR), 64'd0);
    chk("rst_ack", 64'(bus.REQ_ACK), 64'd0);
    chk("rst_data", bus.DATA, 64'd0);
    chk("rst_grant", 64'(bus.GRANT_ID), 64'd0);
    chk("rst_err", 64'(bus.ERR_TMO), 64'd0);
    chk("rst_xfer", 64'(bus.XFER_CNT), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ptr_m  = 0;
    xfer_m = 16'd0;
    rst_n  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n    = 1'b0;
    bus.BUSY = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i]  = 0;
      word[i] = {$urandom, $urandom};
    end
    drive();
    ptr_m  = 0;
    xfer_m = 16'd0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, fixed word, two-cycle latency to WR.
    word[0] = 64'hDEAD_BEEF_0123_4567;
    rem[0]  = 1;
    drive();
    launch(lat);
    chk("ack_latency", 64'(lat), 64'd1);
    finish_ok(10, 0);

    // All four requesters continuously valid: five words from a fresh pointer.
    do_reset();
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    for (int i = 0; i < NR; i++) word[i] = {$urandom, $urandom};
    drive();
    for (int n = 0; n < 5; n++) begin
      launch(lat);
      finish_ok($urandom_range(1, 12), 0);
    end

    // BUSY never rises: timeout, then the timed-out requester loses priority.
    rem[1] = 2; rem[3] = 1;
    word[1] = {$urandom, $urandom};
    word[3] = {$urandom, $urandom};
    drive();
    launch(lat);
    finish_tmo();
    launch(lat);
    finish_ok($urandom_range(1, 12), 0);
    launch(lat);
    finish_ok($urandom_range(1, 12), 0);

    // Link held busy in IDLE: request must wait.
    bus.BUSY = 1'b1;
    rem[2]   = 1;
    word[2]  = {$urandom, $urandom};
    drive();
    check_quiet("busy_in_idle_quiet", 8);
    bus.BUSY = 1'b0;
    launch(lat);
    finish_ok($urandom_range(1, 12), 0);

    // Reset during WAIT_LO, then re-arbitration from index 0.
    rem[3]  = 2;
    word[3] = {$urandom, $urandom};
    drive();
    launch(lat);
    bus.BUSY = 1'b1;
    @(negedge clk);
    rem[1]  = 1;
    word[1] = {$urandom, $urandom};
    drive();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state();
    ptr_m    = 0;
    xfer_m   = 16'd0;
    rst_n    = 1'b1;
    bus.BUSY = 1'b0;
    launch(lat);
    finish_ok($urandom_range(1, 12), 0);
    launch(lat);
    finish_ok($urandom_range(1, 12), 0);

    // One-cycle VALID blip on requester 2 during a transfer is ignored.
    rem[0]  = 1;
    word[0] = {$urandom, $urandom};
    drive();
    launch(lat);
    finish_ok(5, 1);
    check_quiet("blip_never_acked", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
